// File: rtl/video_timing_pkg.sv
// XVGA (1024x768 @ 60 Hz, 65 MHz pixel clock) raster constants, shared by the
// timing generator and the pixel generators that consume hcount/vcount.
package video_timing_pkg;
    localparam int HCOUNT_W = 11;
    localparam int VCOUNT_W = 10;

    localparam int XVGA_H_ACTIVE = 1024;
    localparam int XVGA_H_FP     = 24;
    localparam int XVGA_H_SYNC   = 136;
    localparam int XVGA_H_BP     = 160;
    localparam int XVGA_H_TOTAL  = XVGA_H_ACTIVE + XVGA_H_FP + XVGA_H_SYNC + XVGA_H_BP;

    localparam int XVGA_V_ACTIVE = 768;
    localparam int XVGA_V_FP     = 3;
    localparam int XVGA_V_SYNC   = 6;
    localparam int XVGA_V_BP     = 29;
    localparam int XVGA_V_TOTAL  = XVGA_V_ACTIVE + XVGA_V_FP + XVGA_V_SYNC + XVGA_V_BP;
endpackage

// File: rtl/raster_axis.sv
// One raster axis: wrap counter with increment enable, wrap flag and a sync
// output registered from the next count so it lines up with the counter.
module raster_axis #(
    parameter int   W      = 11,
    parameter int   ACTIVE = 1024,
    parameter int   FP     = 24,
    parameter int   SYNC   = 136,
    parameter int   BP     = 160,
    parameter logic POL    = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] count,
    output logic [W-1:0] count_nxt,
    output logic         wrap,
    output logic         sync
);
    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    assign wrap = en && (count == LAST);

    always_comb begin
        count_nxt = count;
        if (en)
            count_nxt = (count == LAST) ? '0 : count + W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            sync  <= ~POL;
        end else begin
            count <= count_nxt;
            sync  <= (count_nxt >= SYNC_LO && count_nxt < SYNC_HI) ? POL : ~POL;
        end
    end
endmodule

// File: rtl/xvga_timing.sv
// Raster timing generator: pixel coordinates, syncs, blank and line/frame
// strobes, all registered and describing the same pixel in every cycle.
module xvga_timing
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = XVGA_H_ACTIVE,
    parameter int   H_FP      = XVGA_H_FP,
    parameter int   H_SYNC    = XVGA_H_SYNC,
    parameter int   H_BP      = XVGA_H_BP,
    parameter int   V_ACTIVE  = XVGA_V_ACTIVE,
    parameter int   V_FP      = XVGA_V_FP,
    parameter int   V_SYNC    = XVGA_V_SYNC,
    parameter int   V_BP      = XVGA_V_BP,
    parameter logic HSYNC_POL = 1'b0,
    parameter logic VSYNC_POL = 1'b0
) (
    input  logic                vclock,
    input  logic                reset,
    input  logic                pixel_en,
    output logic [HCOUNT_W-1:0] hcount,
    output logic [VCOUNT_W-1:0] vcount,
    output logic                hsync,
    output logic                vsync,
    output logic                blank,
    output logic                frame_start,
    output logic                line_start
);
    if (H_ACTIVE + H_FP + H_SYNC + H_BP > (1 << HCOUNT_W) ||
        V_ACTIVE + V_FP + V_SYNC + V_BP > (1 << VCOUNT_W) ||
        H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_params
        $error("xvga_timing: raster parameters out of range");
    end

    logic [HCOUNT_W-1:0] h_nxt;
    logic [VCOUNT_W-1:0] v_nxt;
    logic                h_wrap;
    logic                v_wrap;

    raster_axis #(
        .W(HCOUNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HSYNC_POL)
    ) u_h (
        .clk(vclock), .reset(reset), .en(pixel_en),
        .count(hcount), .count_nxt(h_nxt), .wrap(h_wrap), .sync(hsync)
    );

    // The vertical axis only steps on the horizontal wrap, so vsync moves with vcount at hcount=0.
    raster_axis #(
        .W(VCOUNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VSYNC_POL)
    ) u_v (
        .clk(vclock), .reset(reset), .en(h_wrap),
        .count(vcount), .count_nxt(v_nxt), .wrap(v_wrap), .sync(vsync)
    );

    // Strobes come from the wrap itself, so the (0,0) held through reset never fires them.
    always_ff @(posedge vclock) begin
        if (reset) begin
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            blank       <= (h_nxt >= HCOUNT_W'(H_ACTIVE)) || (v_nxt >= VCOUNT_W'(V_ACTIVE));
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end
    end
endmodule

// File: tb/tb_xvga_timing.sv
// Directed bench: XVGA instance for the horizontal/stall/reset vectors, plus a
// narrow-line instance with XVGA vertical timing so a full frame stays short.
module tb_xvga_timing;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, en_a = 1'b1, rst_b = 1'b1, en_b = 1'b1;
    logic [10:0] hc_a, hc_b;
    logic [9:0]  vc_a, vc_b;
    logic hs_a, vs_a, bl_a, fs_a, ls_a;
    logic hs_b, vs_b, bl_b, fs_b, ls_b;

    xvga_timing dut_a (
        .vclock(clk), .reset(rst_a), .pixel_en(en_a),
        .hcount(hc_a), .vcount(vc_a), .hsync(hs_a), .vsync(vs_a),
        .blank(bl_a), .frame_start(fs_a), .line_start(ls_a)
    );

    // 24-pixel lines: active 0..15, hsync 18..21; vertical is full XVGA.
    xvga_timing #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2)) dut_b (
        .vclock(clk), .reset(rst_b), .pixel_en(en_b),
        .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b),
        .blank(bl_b), .frame_start(fs_b), .line_start(ls_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        string nm;
        logic  rst;
        logic  en;
        int    n;
        int    h;
        int    v;
        logic  hs, vs, bl, fs, ls;
    } vec_t;

    localparam int NV = 21;
    vec_t vt [NV];

    initial begin
        int hs_lo, ls_cnt, vs_lo, vmin, vmax, k, ph, pv;
        bit found;

        vt[0]  = '{"reset",         1'b1, 1'b1, 3,    0,    0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{"first_adv",     1'b0, 1'b1, 1,    1,    0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{"last_active",   1'b0, 1'b1, 1022, 1023, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{"blank_on",      1'b0, 1'b1, 1,    1024, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[4]  = '{"pre_hsync",     1'b0, 1'b1, 23,   1047, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[5]  = '{"hsync_on",      1'b0, 1'b1, 1,    1048, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{"hsync_last",    1'b0, 1'b1, 135,  1183, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{"hsync_off",     1'b0, 1'b1, 1,    1184, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[8]  = '{"line_end",      1'b0, 1'b1, 159,  1343, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[9]  = '{"line_wrap0",    1'b0, 1'b1, 1,    0,    1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[10] = '{"strobe_off",    1'b0, 1'b1, 1,    1,    1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[11] = '{"line5_end",     1'b0, 1'b1, 6718, 1343, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[12] = '{"line_wrap5",    1'b0, 1'b1, 1,    0,    6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[13] = '{"after_wrap5",   1'b0, 1'b1, 1,    1,    6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[14] = '{"pre_stall",     1'b0, 1'b1, 1342, 1343, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[15] = '{"stall",         1'b0, 1'b0, 5,    1343, 6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[16] = '{"stall_release", 1'b0, 1'b1, 1,    0,    7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[17] = '{"post_stall",    1'b0, 1'b1, 1,    1,    7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[18] = '{"mid_pos",       1'b0, 1'b1, 599,  600,  7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[19] = '{"mid_reset",     1'b1, 1'b1, 1,    0,    0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vt[20] = '{"mid_release",   1'b0, 1'b1, 1,    1,    0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < NV; i++) begin
            rst_a = vt[i].rst;
            en_a  = vt[i].en;
            ls_cnt = 0;
            for (int c = 0; c < vt[i].n; c++) begin
                @(posedge clk); #1;
                if (!vt[i].en && (ls_a || fs_a)) ls_cnt++;
            end
            chk({vt[i].nm, ".hcount"}, 32'(hc_a), 32'(vt[i].h));
            chk({vt[i].nm, ".vcount"}, 32'(vc_a), 32'(vt[i].v));
            chk({vt[i].nm, ".hsync"},  32'(hs_a), 32'(vt[i].hs));
            chk({vt[i].nm, ".vsync"},  32'(vs_a), 32'(vt[i].vs));
            chk({vt[i].nm, ".blank"},  32'(bl_a), 32'(vt[i].bl));
            chk({vt[i].nm, ".frame_start"}, 32'(fs_a), 32'(vt[i].fs));
            chk({vt[i].nm, ".line_start"},  32'(ls_a), 32'(vt[i].ls));
            if (!vt[i].en) chk({vt[i].nm, ".strobes_in_stall"}, 32'(ls_cnt), 32'd0);
        end

        // One full XVGA line from (1,0): exactly 136 hsync-low cycles, one line_start.
        hs_lo = 0; ls_cnt = 0;
        for (int c = 0; c < 1344; c++) begin
            @(posedge clk); #1;
            if (!hs_a) hs_lo++;
            if (ls_a) ls_cnt++;
        end
        chk("hsync_low_per_line", 32'(hs_lo), 32'd136);
        chk("line_starts_per_line", 32'(ls_cnt), 32'd1);
        rst_a = 1'b1;

        // Full frame on the narrow instance: period 24*806, vsync low on lines 771..776.
        rst_b = 1'b0;
        en_b  = 1'b1;
        found = 1'b0; k = 0; vs_lo = 0; vmin = 1023; vmax = 0;
        ph = 0; pv = 0;
        for (int i = 1; i <= 25000 && !found; i++) begin
            @(posedge clk); #1;
            if (!vs_b) begin
                vs_lo++;
                if (int'(vc_b) < vmin) vmin = int'(vc_b);
                if (int'(vc_b) > vmax) vmax = int'(vc_b);
            end
            if (fs_b) begin
                found = 1'b1;
                k = i;
            end else begin
                ph = int'(hc_b);
                pv = int'(vc_b);
            end
        end
        chk("frame_period", 32'(k), 32'd19344);
        chk("pre_wrap_h", 32'(ph), 32'd23);
        chk("pre_wrap_v", 32'(pv), 32'd805);
        chk("frame_wrap_h", 32'(hc_b), 32'd0);
        chk("frame_wrap_v", 32'(vc_b), 32'd0);
        chk("frame_wrap_line_start", 32'(ls_b), 32'd1);
        chk("frame_wrap_blank", 32'(bl_b), 32'd0);
        chk("vsync_low_cycles", 32'(vs_lo), 32'd144);
        chk("vsync_first_line", 32'(vmin), 32'd771);
        chk("vsync_last_line", 32'(vmax), 32'd776);

        @(posedge clk); #1;
        chk("frame_strobe_width", 32'(fs_b), 32'd0);

        // Mid-frame reset at (10,400).
        repeat (9609) @(posedge clk);
        #1;
        chk("mid_b.hcount", 32'(hc_b), 32'd10);
        chk("mid_b.vcount", 32'(vc_b), 32'd400);
        chk("mid_b.blank", 32'(bl_b), 32'd0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk("rst_b.hcount", 32'(hc_b), 32'd0);
        chk("rst_b.vcount", 32'(vc_b), 32'd0);
        chk("rst_b.hsync", 32'(hs_b), 32'd1);
        chk("rst_b.vsync", 32'(vs_b), 32'd1);
        chk("rst_b.blank", 32'(bl_b), 32'd0);
        chk("rst_b.strobes", 32'({fs_b, ls_b}), 32'd0);
        rst_b = 1'b0;
        @(posedge clk); #1;
        chk("rel_b.hcount", 32'(hc_b), 32'd1);
        chk("rel_b.vcount", 32'(vc_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/xvga_timing.md
Name: xvga_timing

Overview:
- Raster timing generator for the 1024x768 @ 60 Hz display path, clocked by the 65 MHz pixel clock.
- Produces the hcount/vcount pixel coordinates consumed by every sprite/shape pixel generator.
- Produces the registered hsync, vsync and blank that go to the VGA DAC, plus frame/line strobes for game-state update logic.
- All outputs are registered and mutually aligned: every output in a given cycle describes the same pixel.

Parameters:
- H_ACTIVE, 1024: visible pixels per line.
- H_FP, 24: horizontal front porch, in pixels.
- H_SYNC, 136: hsync pulse width, in pixels.
- H_BP, 160: horizontal back porch, in pixels. H_TOTAL = 1344.
- V_ACTIVE, 768: visible lines per frame.
- V_FP, 3: vertical front porch, in lines.
- V_SYNC, 6: vsync pulse width, in lines.
- V_BP, 29: vertical back porch, in lines. V_TOTAL = 806.
- HSYNC_POL, 0: active level of hsync (0 = active-low).
- VSYNC_POL, 0: active level of vsync (0 = active-low).

Ports:
- vclock  in  1  pixel clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- pixel_en  in  1  advance enable; tie high for one pixel per clock.
- hcount  out  11  current column, 0..H_TOTAL-1.
- vcount  out  10  current line, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, polarity set by HSYNC_POL.
- vsync  out  1  vertical sync, polarity set by VSYNC_POL.
- blank  out  1  high outside the active region.
- frame_start  out  1  one-cycle strobe at pixel (0,0).
- line_start  out  1  one-cycle strobe at hcount==0.

Behaviour:
- Clocking and reset: one clock, vclock; reset is synchronous and active-high.
- Reset values:
  - hcount=0, vcount=0, blank=0.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - frame_start=0, line_start=0.
  - Reset overrides pixel_en.
  - Reset asserted mid-frame returns to these values on the next edge; there is no partial-line completion.
- Advance rule, on each edge with reset=0 and pixel_en=1:
  - hcount <= (hcount==H_TOTAL-1) ? 0 : hcount+1.
  - When hcount wraps, vcount <= (vcount==V_TOTAL-1) ? 0 : vcount+1. Otherwise vcount holds.
- Stall: pixel_en=0 holds hcount, vcount, hsync, vsync and blank. frame_start and line_start are forced to 0 during a stall (each strobe lasts exactly one advancing cycle).
- Decode, registered from the next-state coordinates so it aligns with the counters (zero relative latency):
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183.
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776. vsync changes only together with vcount, at hcount=0.
  - blank = (hcount >= H_ACTIVE) || (vcount >= V_ACTIVE).
  - line_start = 1 in the cycle outputs first show hcount=0 after an advance.
  - frame_start = 1 in the cycle outputs first show (0,0) after an advance. The (0,0) held during and just after reset does not raise either strobe, so the first frame_start follows one full frame.
- Widths:
  - Comparisons are unsigned at 11 bits (horizontal) and 10 bits (vertical).
  - Elaboration check: H_TOTAL <= 2048, V_TOTAL <= 1024, and every porch/sync parameter >= 1; fail elaboration otherwise.
- Latency from reset release: the first advancing edge shows (1,0).

Decomposition:
- Package video_timing_pkg holds the XVGA constants (the active, porch, sync and total values for both axes) and the HCOUNT_W=11 / VCOUNT_W=10 widths, shared with the pixel generators.
- Sub-module raster_axis is natural: a generic wrap counter with increment-enable, wrap output and a registered sync-window decode. It is instantiated once for the horizontal axis; the vertical instance is enabled by the horizontal wrap.
- The top level adds blank and the two strobes.

Test Plan:
- Reset for 3 cycles, then release with pixel_en=1 -> reset values as listed. Next cycle shows (1,0); frame_start stays 0.
- Line wrap: run to hcount=1343, vcount=5, next edge -> hcount=0, vcount=6, line_start=1 for one cycle, blank=0.
- Horizontal window: step across hcount 1023->1024 -> blank 0->1. Step 1047->1048 -> hsync 1->0. Step 1183->1184 -> hsync 0->1. Counting hsync-low cycles per line gives exactly 136.
- Frame wrap: at (1343,805), next edge -> (0,0) with frame_start=1 and line_start=1. Over one frame, vsync is low only for vcount 771..776 (6 lines); the frame period is 1344*806 = 1,083,264 cycles.
- Stall: drop pixel_en for 5 cycles at hcount=1343 -> all outputs hold and strobes stay 0. On re-enable, wrap to hcount=0 with line_start=1 exactly once.
- Mid-frame reset at (600,400) for one cycle -> next cycle shows (0,0), blank=0, both syncs inactive, strobes 0, then normal advance.
